// File: rtl/frame_byte_loader_if.sv
// rtl/frame_byte_loader_if.sv - byte stream, BRAM write port and status bundle of the frame loader
interface frame_byte_loader_if #(
    parameter int CNT_W = 18
);
    logic             start;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             hold;
    logic             addr_clr;
    logic             wea;
    logic [7:0]       dina;
    logic             count;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [CNT_W-1:0] bytes_written;
    logic [7:0]       checksum;

    // Control side: drives start, the UART byte stream and hold; observes the loader.
    modport master (
        output start, rx_data, rx_valid, hold,
        input  addr_clr, wea, dina, count, busy, done, overflow, bytes_written, checksum
    );

    // Loader side.
    modport slave (
        input  start, rx_data, rx_valid, hold,
        output addr_clr, wea, dina, count, busy, done, overflow, bytes_written, checksum
    );
endinterface

// File: rtl/frame_byte_loader.sv
// rtl/frame_byte_loader.sv - buffers UART bytes and writes one frame to BRAM; optional LOADER_CHECKSUM_EN
module frame_byte_loader #(
    parameter int DEPTH_BYTES = 196608,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_byte_loader_if.slave    bus
);
    localparam int               AW      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             addr_clr_q;
    logic             wea_q;
    logic [7:0]       dina_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;
    logic [CNT_W-1:0] bytes_written_q;
    logic [CNT_W-1:0] accepted_q;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [7:0]       mem [FIFO_DEPTH];

    logic             in_load;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             can_take;
    logic             push;
    logic             drop;
    logic [7:0]       head;

    // FIFO status from pointer difference and the push/pop/drop decisions for this cycle.
    always_comb begin
        in_load    = (state_q == LOAD);
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head       = mem[rd_ptr_q[AW-1:0]];
        // No write in the clear cycle so the counter sees its clear before the first count.
        pop        = in_load && !fifo_empty && !bus.hold && !addr_clr_q &&
                     (bytes_written_q != DEPTH_C);
        can_take   = in_load && bus.rx_valid && (accepted_q < DEPTH_C);
        push       = can_take && (!fifo_full || pop);
        drop       = can_take && fifo_full && !pop;
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.rx_data;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum_q;
    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = 8'd0;
`endif

    // Load sequencer: state, FIFO pointers, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_clr_q      <= 1'b0;
            wea_q           <= 1'b0;
            dina_q          <= 8'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            overflow_q      <= 1'b0;
            bytes_written_q <= '0;
            accepted_q      <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q      <= 8'd0;
`endif
        end else begin
            addr_clr_q <= 1'b0;
            wea_q      <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q         <= LOAD;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        addr_clr_q      <= 1'b1;
                        overflow_q      <= 1'b0;
                        bytes_written_q <= '0;
                        accepted_q      <= '0;
                        wr_ptr_q        <= '0;
                        rd_ptr_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
                        checksum_q      <= 8'd0;
`endif
                    end
                end
                LOAD: begin
                    if (push) begin
                        wr_ptr_q   <= wr_ptr_q + (AW+1)'(1);
                        accepted_q <= accepted_q + CNT_W'(1);
                    end
                    if (drop) begin
                        overflow_q <= 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_q        <= rd_ptr_q + (AW+1)'(1);
                        wea_q           <= 1'b1;
                        dina_q          <= head;
                        bytes_written_q <= bytes_written_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        checksum_q      <= checksum_q + head;
`endif
                    end
                    // The final write is visible this cycle; finish on the next.
                    if (bytes_written_q == DEPTH_C) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_clr      = addr_clr_q;
    assign bus.wea           = wea_q;
    assign bus.count         = wea_q;
    assign bus.dina          = dina_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.overflow      = overflow_q;
    assign bus.bytes_written = bytes_written_q;
endmodule

// File: tb/tb_frame_byte_loader.sv
// tb/tb_frame_byte_loader.sv - directed bench for frame_byte_loader with DEPTH_BYTES=16, FIFO_DEPTH=4
module tb_frame_byte_loader;
    localparam int DEPTH = 16;
    localparam int CNT_W = 18;

    logic clk;
    logic reset;

    frame_byte_loader_if #(.CNT_W(CNT_W)) bus ();

    frame_byte_loader #(
        .DEPTH_BYTES (DEPTH),
        .FIFO_DEPTH  (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    int         n_clr    = 0;
    int         n_mis    = 0;
    logic [7:0] wq[$];
    int         wc[$];

    // Write observer: records every BRAM write with its cycle number.
    always @(negedge clk) begin
        cyc++;
        if (bus.wea === 1'b1) begin
            wq.push_back(bus.dina);
            wc.push_back(cyc);
        end
        if (bus.addr_clr === 1'b1) n_clr++;
        if (bus.count !== bus.wea) n_mis++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wdat(input int i);
        return (i < wq.size()) ? {24'd0, wq[i]} : 32'hDEAD;
    endfunction

    function automatic int wcyc(input int i);
        return (i < wc.size()) ? wc[i] : -1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        wc.delete();
        n_clr = 0;
        n_mis = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", {31'd0, bus.done}, 32'd1);
    endtask

    logic [7:0] csum;

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        bus.hold     = 1'b0;
        tick();
        tick();
        check("rst_busy",     {31'd0, bus.busy},     32'd0);
        check("rst_done",     {31'd0, bus.done},     32'd0);
        check("rst_wea",      {31'd0, bus.wea},      32'd0);
        check("rst_addr_clr", {31'd0, bus.addr_clr}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_bytes",    32'(bus.bytes_written), 32'd0);
        check("rst_checksum", {24'd0, bus.checksum}, 32'd0);
        reset = 1'b0;
        tick();

        // Full frame of 0x00..0x0F spaced three cycles apart.
        clear_mon();
        do_start();
        check("t1_addr_clr_first", {31'd0, bus.addr_clr}, 32'd1);
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            tick();
            tick();
        end
        wait_done(50);
        check("t1_clr_pulses", n_clr, 32'd1);
        check("t1_writes", wq.size(), 32'd16);
        for (int i = 0; i < 16; i++) check($sformatf("t1_dina%0d", i), wdat(i), 32'(i));
        check("t1_count_eq_wea", n_mis, 32'd0);
        check("t1_done", {31'd0, bus.done}, 32'd1);
        check("t1_busy_end", {31'd0, bus.busy}, 32'd0);
        check("t1_bytes", 32'(bus.bytes_written), 32'd16);
`ifdef LOADER_CHECKSUM_EN
        check("t1_checksum", {24'd0, bus.checksum}, 32'h78);
`else
        check("t1_checksum", {24'd0, bus.checksum}, 32'h00);
`endif
        tick();
        tick();
        check("t1_done_stable_bytes", 32'(bus.bytes_written), 32'd16);

        // Hold over a burst that just fits the FIFO.
        apply_reset();
        clear_mon();
        bus.hold = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) tick();
        check("t2_no_write_hold", wq.size(), 32'd0);
        bus.hold = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t2_writes", wq.size(), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("t2_dina%0d", i), wdat(i), 32'hA0 + 32'(i));
        check("t2_consecutive", 32'(wcyc(3) - wcyc(0)), 32'd3);
        check("t2_overflow", {31'd0, bus.overflow}, 32'd0);
        check("t2_bytes", 32'(bus.bytes_written), 32'd4);

        // Hold over a burst that overruns the FIFO.
        apply_reset();
        clear_mon();
        bus.hold = 1'b1;
        do_start();
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        check("t3_overflow", {31'd0, bus.overflow}, 32'd1);
        bus.hold = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t3_writes", wq.size(), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_dina%0d", i), wdat(i), 32'h10 + 32'(i));
        check("t3_bytes", 32'(bus.bytes_written), 32'd4);

        // More bytes than a frame: the extra ones are ignored.
        apply_reset();
        clear_mon();
        do_start();
        for (int i = 0; i < 20; i++) begin
            send_byte(8'h40 + 8'(i));
            tick();
        end
        wait_done(20);
        for (int i = 0; i < 4; i++) tick();
        check("t4_writes", wq.size(), 32'd16);
        check("t4_first", wdat(0), 32'h40);
        check("t4_last", wdat(15), 32'h4F);
        check("t4_overflow", {31'd0, bus.overflow}, 32'd0);
        check("t4_bytes", 32'(bus.bytes_written), 32'd16);

        // Reset in the middle of a load.
        apply_reset();
        clear_mon();
        do_start();
        for (int i = 0; i < 7; i++) begin
            send_byte(8'h60 + 8'(i));
            tick();
            tick();
        end
        check("t5_writes_before", wq.size(), 32'd7);
        check("t5_bytes_before", 32'(bus.bytes_written), 32'd7);
        reset = 1'b1;
        #2;
        check("t5_async_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_async_bytes", 32'(bus.bytes_written), 32'd0);
        check("t5_async_wea", {31'd0, bus.wea}, 32'd0);
        tick();
        reset = 1'b0;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h70);
            tick();
        end
        check("t5_idle_no_write", wq.size(), 32'd0);
        check("t5_idle_overflow", {31'd0, bus.overflow}, 32'd0);
        do_start();
        check("t5_restart_clr", {31'd0, bus.addr_clr}, 32'd1);
        check("t5_restart_bytes", 32'(bus.bytes_written), 32'd0);
        send_byte(8'h55);
        tick();
        tick();
        check("t5_restart_write", wdat(0), 32'h55);
        check("t5_restart_count", 32'(bus.bytes_written), 32'd1);

        // Start ignored in LOAD, honoured in DONE.
        apply_reset();
        clear_mon();
        bus.hold = 1'b1;
        do_start();
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        bus.hold = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        do_start();
        check("t6_no_second_clr", n_clr, 32'd1);
        check("t6_bytes_mid", 32'(bus.bytes_written), 32'd4);
        csum = 8'h10 + 8'h11 + 8'h12 + 8'h13;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'h20 + 8'(i));
            csum = csum + 8'h20 + 8'(i);
            tick();
        end
        wait_done(20);
        check("t6_writes", wq.size(), 32'd16);
        check("t6_bytes", 32'(bus.bytes_written), 32'd16);
        check("t6_overflow_kept", {31'd0, bus.overflow}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
        check("t6_checksum", {24'd0, bus.checksum}, {24'd0, csum});
`else
        check("t6_checksum", {24'd0, bus.checksum}, 32'd0);
`endif
        do_start();
        check("t6_reload_clr", {31'd0, bus.addr_clr}, 32'd1);
        check("t6_reload_busy", {31'd0, bus.busy}, 32'd1);
        check("t6_reload_overflow", {31'd0, bus.overflow}, 32'd0);
        check("t6_reload_checksum", {24'd0, bus.checksum}, 32'd0);
        check("t6_reload_bytes", 32'(bus.bytes_written), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
